// File: rtl/sample_strobe.sv
// sample_strobe: single-cycle sample strobe generator for the correlator front end.
//   Periodic mode emits one strobe every 2**r cycles; nonperiodic mode draws each
//   interval from an LFSR, centred on 2**r cycles.
//   Optional feature macro: SAMPLE_STROBE_COUNT_EN (adds the o_strobeCount counter).
// Ports:
//   i_clk                    clock
//   i_rst_n                  asynchronous active-low reset
//   i_cg                     clock gate, 0 = every flop holds
//   i_reg_sampleRateNegExp   r, interval exponent (clipped to MAX_SAMPLE_RATE_NEGEXP)
//   i_reg_sampleMode         0 = periodic, 1 = nonperiodic
//   i_reg_sampleJitterNegExp j, jitter exponent (clipped to MAX_SAMPLE_JITTER_NEGEXP)
//   o_strobe                 registered one-cycle sample strobe
//   o_strobeCount            strobes since last restart (0 unless SAMPLE_STROBE_COUNT_EN)
module sample_strobe #(
    parameter int          MAX_SAMPLE_RATE_NEGEXP   = 31,
    parameter int          MAX_SAMPLE_JITTER_NEGEXP = 31,
    parameter logic [31:0] LFSR_SEED                = 32'hACE1_0001,
    localparam int         RW_   = $clog2(MAX_SAMPLE_RATE_NEGEXP),
    localparam int         JW_   = $clog2(MAX_SAMPLE_JITTER_NEGEXP),
    localparam int         CNT_W = MAX_SAMPLE_RATE_NEGEXP + 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_cg,
    input  logic [RW_-1:0] i_reg_sampleRateNegExp,
    input  logic           i_reg_sampleMode,
    input  logic [JW_-1:0] i_reg_sampleJitterNegExp,
    output logic           o_strobe,
    output logic [15:0]    o_strobeCount
);
    localparam int CFG_W = RW_ + 1 + JW_;

    logic [CNT_W-1:0] r_cnt;
    logic [CFG_W-1:0] r_shadow;
    logic [31:0]      r_lfsr;
    logic             r_strobe;

    logic [31:0]      w_r;
    logic [31:0]      w_j;
    logic [31:0]      w_k;
    logic             w_jit;
    logic [CNT_W-1:0] w_base;
    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_mask;
    logic [CNT_W-1:0] w_len;
    logic [CFG_W-1:0] w_cfg;
    logic             w_chg;
    logic             w_strobe_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic [31:0]      w_lfsr_d;

    assign w_r = (32'(i_reg_sampleRateNegExp) > 32'(MAX_SAMPLE_RATE_NEGEXP)) ?
                 32'(MAX_SAMPLE_RATE_NEGEXP) : 32'(i_reg_sampleRateNegExp);
    assign w_j = (32'(i_reg_sampleJitterNegExp) > 32'(MAX_SAMPLE_JITTER_NEGEXP)) ?
                 32'(MAX_SAMPLE_JITTER_NEGEXP) : 32'(i_reg_sampleJitterNegExp);

    // Jitter window spans 2**k values centred on 2**r; only when j' < r'
    assign w_jit  = i_reg_sampleMode && (w_j < w_r);
    assign w_k    = w_r - w_j;
    assign w_base = CNT_W'(1) << w_r;
    assign w_half = CNT_W'(1) << (w_k - 32'd1);
    assign w_mask = (CNT_W'(1) << w_k) - CNT_W'(1);
    assign w_len  = w_jit ? w_base - w_half + (CNT_W'(r_lfsr) & w_mask) : w_base;

    // A config change restarts the interval and suppresses a coincident strobe
    assign w_cfg      = {i_reg_sampleRateNegExp, i_reg_sampleMode, i_reg_sampleJitterNegExp};
    assign w_chg      = w_cfg != r_shadow;
    assign w_strobe_d = (r_cnt == '0) && !w_chg;
    assign w_cnt_d    = ((r_cnt == '0) || w_chg) ? w_len - CNT_W'(1) : r_cnt - CNT_W'(1);

    // Galois right-shift LFSR, x^32+x^22+x^2+x+1; a nonzero seed never reaches 0
    assign w_lfsr_d = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_shadow <= '0;
            r_lfsr   <= LFSR_SEED;
            r_strobe <= 1'b0;
        end else if (i_cg) begin
            r_cnt    <= w_cnt_d;
            r_shadow <= w_cfg;
            r_lfsr   <= w_lfsr_d;
            r_strobe <= w_strobe_d;
        end
    end

    assign o_strobe = r_strobe;

`ifdef SAMPLE_STROBE_COUNT_EN
    logic [15:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (i_cg)
            r_count <= w_chg ? 16'd0 : r_count + {15'd0, w_strobe_d};
    end

    assign o_strobeCount = r_count;
`else
    assign o_strobeCount = 16'd0;
`endif

endmodule

// File: tb/tb_sample_strobe.sv
// tb_sample_strobe: scoreboard bench for sample_strobe with an event-scheduled reference model.
module tb_sample_strobe;
    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic        clk;
    logic        rst_n;
    logic        i_cg;
    logic [4:0]  r_in;
    logic        m_in;
    logic [4:0]  j_in;
    logic        o_strobe;
    logic [15:0] o_strobeCount;

    sample_strobe dut (
        .i_clk                   (clk),
        .i_rst_n                 (rst_n),
        .i_cg                    (i_cg),
        .i_reg_sampleRateNegExp  (r_in),
        .i_reg_sampleMode        (m_in),
        .i_reg_sampleJitterNegExp(j_in),
        .o_strobe                (o_strobe),
        .o_strobeCount           (o_strobeCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [15:0] c;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;

    // Model: strobes are scheduled as absolute gated-edge indices
    longint      m_edge = 0;
    longint      m_due  = 1;
    logic [31:0] m_lfsr = SEED;
    logic [10:0] m_shadow = '0;
    logic        m_strobe = 1'b0;
    logic [15:0] m_count = '0;
    longint      g_edge = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        logic [31:0] n;
        n = v >> 1;
        if (v[0]) begin
            n[31] = ~n[31];
            n[21] = ~n[21];
            n[1]  = ~n[1];
            n[0]  = ~n[0];
        end
        return n;
    endfunction

    function automatic longint interval(input int r, input bit m, input int j, input logic [31:0] lf);
        int     rr;
        int     jj;
        int     k;
        longint p;
        rr = (r > 31) ? 31 : r;
        jj = (j > 31) ? 31 : j;
        p  = longint'(1) << rr;
        if (m && jj < rr) begin
            k = rr - jj;
            return p - (longint'(1) << (k - 1)) + (longint'(lf) & ((longint'(1) << k) - 1));
        end
        return p;
    endfunction

    task automatic step(input bit cg, input int r, input bit m, input int j);
        logic [10:0] cfg;
        longint      len;
        logic [15:0] ec;
        i_cg = cg;
        r_in = 5'(r);
        m_in = m;
        j_in = 5'(j);
        if (cg) begin
            cfg = {r_in, m_in, j_in};
            m_edge++;
            len = interval(r, m, j, m_lfsr);
            if (cfg != m_shadow) begin
                m_strobe = 1'b0;
                m_due    = m_edge + len;
                m_count  = '0;
            end else if (m_edge == m_due) begin
                m_strobe = 1'b1;
                m_due    = m_edge + len;
                m_count  = m_count + 16'd1;
            end else begin
                m_strobe = 1'b0;
            end
            m_lfsr   = lfsr_next(m_lfsr);
            m_shadow = cfg;
        end
`ifdef SAMPLE_STROBE_COUNT_EN
        ec = m_count;
`else
        ec = 16'd0;
`endif
        q.push_back('{m_strobe, ec});
        @(negedge clk);
        g_edge++;
    endtask

    task automatic model_reset();
        m_lfsr   = SEED;
        m_shadow = '0;
        m_due    = m_edge + 1;
        m_strobe = 1'b0;
        m_count  = '0;
    endtask

    // Entered at a negedge; asserts reset between edges and returns at a negedge
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("reset_strobe", o_strobe, 0);
        check("reset_count", o_strobeCount, 0);
        q.push_back('{1'b0, 16'd0});
        @(negedge clk);
        g_edge++;
        q.push_back('{1'b0, 16'd0});
        @(negedge clk);
        g_edge++;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_strobe(input int r, input bit m, input int j, input int limit,
                               input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            step(1'b1, r, m, j);
            hit = o_strobe;
        end
        check(nm, hit, 1);
    endtask

    // Monitor: every clock edge produces one output beat to compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sb_strobe", o_strobe, e.s);
                check("sb_count", o_strobeCount, e.c);
            end
        end
    end

    initial begin
        longint s;
        longint last;
        longint sum;
        int     n;
        bit     have;
        int     cr;
        bit     cm;
        int     cj;
        rst_n = 1'b1;
        i_cg  = 1'b1;
        r_in  = 5'd3;
        m_in  = 1'b0;
        j_in  = 5'd0;
        #1 rst_n = 1'b0;
        #2;
        check("init_strobe", o_strobe, 0);
        check("init_count", o_strobeCount, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 1; i <= 28; i++) begin
            step(1'b1, 3, 1'b0, 0);
            if (i <= 25)
                check("periodic_edge", o_strobe, (i == 9 || i == 17 || i == 25) ? 1 : 0);
        end

        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 0, 1'b0, 0);
            check("r0_continuous", o_strobe, 1);
        end

        have = 1'b0;
        n    = 0;
        sum  = 0;
        last = 0;
        for (int i = 0; i < 20000 && n < 1000; i++) begin
            step(1'b1, 4, 1'b1, 1);
            if (o_strobe) begin
                if (have) begin
                    check("jitter_range", (g_edge - last >= 12 && g_edge - last <= 19) ? 1 : 0, 1);
                    sum += g_edge - last;
                    n++;
                end
                have = 1'b1;
                last = g_edge;
            end
        end
        check("jitter_intervals", n, 1000);
        check("jitter_mean", (sum >= 15000 && sum <= 16000) ? 1 : 0, 1);

        wait_strobe(2, 1'b0, 0, 20, "collide_sync");
        s = g_edge;
        for (int i = 0; i < 3; i++)
            step(1'b1, 2, 1'b0, 0);
        step(1'b1, 3, 1'b0, 0);
        check("collide_no_strobe", o_strobe, 0);
        wait_strobe(3, 1'b0, 0, 20, "collide_found");
        check("collide_gap", g_edge - s, 12);
        s = g_edge;
        wait_strobe(3, 1'b0, 0, 20, "collide_found2");
        check("collide_period", g_edge - s, 8);

        wait_strobe(2, 1'b0, 0, 20, "gate_sync");
        wait_strobe(2, 1'b0, 0, 20, "gate_sync2");
        s = g_edge;
        step(1'b1, 2, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2, 1'b0, 0);
            check("gate_hold", o_strobe, 0);
        end
        wait_strobe(2, 1'b0, 0, 20, "gate_found");
        check("gate_gap", g_edge - s, 9);

        step(1'b1, 2, 1'b0, 0);
        do_reset();

        cr = 2;
        cm = 1'b0;
        cj = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                cr = $urandom_range(0, 6);
                cm = 1'($urandom_range(0, 1));
                cj = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5);
            end
            step($urandom_range(0, 9) != 0, cr, cm, cj);
        end

`ifdef SAMPLE_STROBE_COUNT_EN
        do_reset();
        for (int i = 1; i <= 65536; i++) begin
            step(1'b1, 0, 1'b0, 0);
            if (i == 65535)
                check("count_max", o_strobeCount, 65535);
        end
        check("count_wrap", o_strobeCount, 0);
`else
        check("count_tied", o_strobeCount, 0);
`endif

        @(negedge clk);
        check("sb_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
